plot_arbiter: RTL and testbench

Shares the single write port of the 160x120 VGA frame-buffer adapter among several pixel producers (snake body/tail-erase engine, food spawner, score/border painter). Each producer presents one pixel per valid/ready handshake; a round-robin arbiter grants one producer per cycle and registers the winning pixel onto the adapter's x/y/colour/plot inputs. An optional built-in sweep engine clears the whole screen on request, taking priority over all producers while it runs.

---
 rtl/plot_arb_pkg.sv | 28 ++
 rtl/plot_arbiter_rr.sv | 41 ++++
 rtl/plot_arbiter.sv | 160 ++++++++++++++++
 tb/tb_plot_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : plot_arb_pkg
//  Brief    : Shared widths, screen limits, arbiter state encoding and a
//             pointer-width helper for the frame-buffer plot arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package plot_arb_pkg;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   localparam int X_MAX_DEF = 159;
   localparam int Y_MAX_DEF = 119;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Width of an encoded requester index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : plot_arb_pkg
`default_nettype wire

// File: rtl/plot_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick. Search starts one past the
//             last granted requester and wraps; returns a one-hot grant,
//             its encoded index and a flag telling whether anyone won.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
   import plot_arb_pkg::*;
#(
   parameter int  NREQ = 3,
   localparam int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            grant_valid
);

   int w_idx;

   // Walk the requesters in rotated order and keep the first one asserting.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      w_idx       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = (int'(last_grant) + k) % NREQ;
         if (!grant_valid && req[w_idx]) begin
            grant_valid  = 1'b1;
            grant_idx    = IW'(w_idx);
            grant[w_idx] = 1'b1;
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : plot_arbiter
//  Brief    : Shares the VGA adapter write port among NREQ pixel producers
//             with round-robin valid/ready arbitration and a registered
//             pixel stage. Out-of-range pixels are accepted and dropped.
//             With PLOT_ARB_CLEAR_EN defined, a full-screen clear sweep
//             (one pixel per cycle) preempts all producers while it runs.
//  Revision : 1.0  initial release
// ============================================================================
module plot_arbiter
   import plot_arb_pkg::*;
#(
   parameter int             NREQ         = 3,
   parameter int             X_MAX        = X_MAX_DEF,
   parameter int             Y_MAX        = Y_MAX_DEF,
   parameter logic [C_W-1:0] CLEAR_COLOUR = 3'b000
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [X_W*NREQ-1:0] req_x,
   input  logic [Y_W*NREQ-1:0] req_y,
   input  logic [C_W*NREQ-1:0] req_colour,
   input  logic                clear_start,
   output logic                clear_busy,
   output logic                clear_done,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [C_W-1:0]      vga_colour,
   output logic                vga_plot,
   output logic                drop
);

   localparam int             IW      = idx_w(NREQ);
   localparam logic [X_W-1:0] c_x_max = X_W'(X_MAX);
   localparam logic [Y_W-1:0] c_y_max = Y_W'(Y_MAX);

   logic [IW-1:0]   r_last_grant;
   logic            w_allow;
   logic [NREQ-1:0] w_req;
   logic [NREQ-1:0] w_grant;
   logic [IW-1:0]   w_grant_idx;
   logic            w_grant_valid;
   logic [X_W-1:0]  w_sel_x;
   logic [Y_W-1:0]  w_sel_y;
   logic [C_W-1:0]  w_sel_c;
   logic            w_in_range;

`ifdef PLOT_ARB_CLEAR_EN
   state_t          r_state;
   logic [X_W-1:0]  r_cnt_x;
   logic [Y_W-1:0]  r_cnt_y;
   logic            r_sweep_end;

   // Producers are locked out while sweeping and on the cycle a clear is requested.
   assign w_allow = (r_state == IDLE) && !clear_start;
`else
   // Without the sweep engine the producers own the port every cycle.
   assign w_allow = 1'b1;
   assign clear_busy = 1'b0;
   assign clear_done = 1'b0;
   wire   w_unused   = ^{clear_start, CLEAR_COLOUR};
`endif

   assign w_req     = req_valid & {NREQ{w_allow}};
   assign req_ready = w_grant;

   rr_arbiter #(
      .NREQ        (NREQ)
   ) u_rr (
      .req         (w_req),
      .last_grant  (r_last_grant),
      .grant       (w_grant),
      .grant_idx   (w_grant_idx),
      .grant_valid (w_grant_valid)
   );

   assign w_sel_x    = req_x[X_W*w_grant_idx +: X_W];
   assign w_sel_y    = req_y[Y_W*w_grant_idx +: Y_W];
   assign w_sel_c    = req_colour[C_W*w_grant_idx +: C_W];
   assign w_in_range = (w_sel_x <= c_x_max) && (w_sel_y <= c_y_max);

   // Register the winning pixel (or the next sweep pixel) onto the adapter inputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_last_grant <= IW'(NREQ - 1);
         vga_x        <= '0;
         vga_y        <= '0;
         vga_colour   <= '0;
         vga_plot     <= 1'b0;
         drop         <= 1'b0;
`ifdef PLOT_ARB_CLEAR_EN
         r_state      <= IDLE;
         r_cnt_x      <= '0;
         r_cnt_y      <= '0;
         r_sweep_end  <= 1'b0;
         clear_busy   <= 1'b0;
         clear_done   <= 1'b0;
`endif
      end else begin
         vga_plot <= 1'b0;
         drop     <= 1'b0;

         // The grant is already gated off during a sweep, so these paths never collide.
         if (w_grant_valid) begin
            r_last_grant <= w_grant_idx;
            vga_x        <= w_sel_x;
            vga_y        <= w_sel_y;
            vga_colour   <= w_sel_c;
            if (w_in_range) vga_plot <= 1'b1;
            else            drop     <= 1'b1;
         end

`ifdef PLOT_ARB_CLEAR_EN
         clear_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (clear_start) begin
                  r_state     <= CLEAR;
                  clear_busy  <= 1'b1;
                  r_cnt_x     <= '0;
                  r_cnt_y     <= '0;
                  r_sweep_end <= 1'b0;
               end
            end
            CLEAR: begin
               // One extra cycle after the last pixel keeps busy high alongside clear_done.
               if (r_sweep_end) begin
                  r_state     <= IDLE;
                  clear_busy  <= 1'b0;
                  r_sweep_end <= 1'b0;
               end else begin
                  vga_x      <= r_cnt_x;
                  vga_y      <= r_cnt_y;
                  vga_colour <= CLEAR_COLOUR;
                  vga_plot   <= 1'b1;
                  if (r_cnt_x == c_x_max) begin
                     r_cnt_x <= '0;
                     if (r_cnt_y == c_y_max) begin
                        r_cnt_y     <= '0;
                        clear_done  <= 1'b1;
                        r_sweep_end <= 1'b1;
                     end else begin
                        r_cnt_y <= r_cnt_y + 1'b1;
                     end
                  end else begin
                     r_cnt_x <= r_cnt_x + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
`endif
      end
   end

endmodule : plot_arbiter
`default_nettype wire

// File: tb/tb_plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plot_arbiter
//  Brief    : Self-checking bench for plot_arbiter. A pixel-level model of
//             the arbitration and clear sweep is compared every cycle, and
//             directed scenarios pin the model with literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_plot_arbiter;

   localparam int NREQ   = 3;
   localparam int XMAX   = 159;
   localparam int YMAX   = 119;
   localparam int NPIX   = (XMAX + 1) * (YMAX + 1);
`ifdef PLOT_ARB_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            resetn;
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [8*NREQ-1:0] req_x;
   logic [7*NREQ-1:0] req_y;
   logic [3*NREQ-1:0] req_colour;
   logic            clear_start;
   logic            clear_busy;
   logic            clear_done;
   logic [7:0]      vga_x;
   logic [6:0]      vga_y;
   logic [2:0]      vga_colour;
   logic            vga_plot;
   logic            drop;

   int errors = 0;
   int checks = 0;

   plot_arbiter #(
      .NREQ         (NREQ),
      .X_MAX        (XMAX),
      .Y_MAX        (YMAX),
      .CLEAR_COLOUR (3'b000)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_x        (req_x),
      .req_y        (req_y),
      .req_colour   (req_colour),
      .clear_start  (clear_start),
      .clear_busy   (clear_busy),
      .clear_done   (clear_done),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .vga_plot     (vga_plot),
      .drop         (drop)
   );

   always #10 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit         m_init  = 1'b0;
   int         m_last;
   bit         m_sweep;
   bit         m_tail;
   int         m_pix;
   logic [7:0] e_x;
   logic [6:0] e_y;
   logic [2:0] e_c;
   logic       e_plot, e_drop, e_busy, e_done;

   // Compare on the falling edge, then advance the model to the next rising edge.
   always @(negedge clk) begin
      int         win;
      int         px, py, pc;
      logic [NREQ-1:0] e_ready;
      if (m_init) begin
         checks++;
         if ({vga_x, vga_y, vga_colour, vga_plot, drop, clear_busy, clear_done} !==
             {e_x, e_y, e_c, e_plot, e_drop, e_busy, e_done}) begin
            errors++;
            $display("FAIL outputs @%0t: got x=%0d y=%0d c=%0d plot=%b drop=%b busy=%b done=%b, expected x=%0d y=%0d c=%0d plot=%b drop=%b busy=%b done=%b",
                     $time, vga_x, vga_y, vga_colour, vga_plot, drop, clear_busy, clear_done,
                     e_x, e_y, e_c, e_plot, e_drop, e_busy, e_done);
         end
      end
      if (!resetn) begin
         m_last = NREQ - 1;
         m_sweep = 1'b0; m_tail = 1'b0; m_pix = 0;
         e_x = '0; e_y = '0; e_c = '0;
         e_plot = 1'b0; e_drop = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         m_init = 1'b1;
      end else if (m_init) begin
         win = -1;
         if (!m_sweep && !m_tail && !(CLR_EN && clear_start)) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (win < 0 && req_valid[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
            end
         end
         e_ready = (win >= 0) ? NREQ'(1 << win) : '0;
         checks++;
         if (req_ready !== e_ready) begin
            errors++;
            $display("FAIL req_ready @%0t: got %b expected %b", $time, req_ready, e_ready);
         end
         e_plot = 1'b0; e_drop = 1'b0; e_done = 1'b0;
         if (m_tail) begin
            m_tail = 1'b0;
            e_busy = 1'b0;
         end else if (m_sweep) begin
            e_x = 8'(m_pix % (XMAX + 1));
            e_y = 7'(m_pix / (XMAX + 1));
            e_c = 3'b000;
            e_plot = 1'b1;
            m_pix++;
            if (m_pix == NPIX) begin
               m_sweep = 1'b0; m_tail = 1'b1; e_done = 1'b1;
            end
         end else if (CLR_EN && clear_start) begin
            m_sweep = 1'b1; m_pix = 0; e_busy = 1'b1;
         end else if (win >= 0) begin
            m_last = win;
            px = int'(req_x[8*win +: 8]);
            py = int'(req_y[7*win +: 7]);
            pc = int'(req_colour[3*win +: 3]);
            e_x = 8'(px); e_y = 7'(py); e_c = 3'(pc);
            if (px <= XMAX && py <= YMAX) e_plot = 1'b1;
            else                          e_drop = 1'b1;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic set_px(input int i, input int x, input int y, input int c);
      req_x[8*i +: 8]      = 8'(x);
      req_y[7*i +: 7]      = 7'(y);
      req_colour[3*i +: 3] = 3'(c);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
   endtask

   initial begin
      int n, cnt;
      resetn = 1'b0; req_valid = '0; req_x = '0; req_y = '0; req_colour = '0;
      clear_start = 1'b0;
      step(); step();
      resetn = 1'b1;
      chk("reset plot", int'(vga_plot), 0);
      chk("reset x", int'(vga_x), 0);
      chk("reset busy", int'(clear_busy), 0);
      chk("reset done", int'(clear_done), 0);
      chk("reset drop", int'(drop), 0);

      // single pixel from requester 0
      set_px(0, 80, 60, 7);
      req_valid = 3'b001;
      @(negedge clk);
      chk("first ready", int'(req_ready), 1);
      step();
      req_valid = '0;
      chk("first plot", int'(vga_plot), 1);
      chk("first x", int'(vga_x), 80);
      chk("first y", int'(vga_y), 60);
      chk("first colour", int'(vga_colour), 7);

      // all three contending from reset: 0,1,2,0,1,2
      do_reset();
      set_px(0, 10, 1, 1); set_px(1, 20, 2, 2); set_px(2, 30, 3, 3);
      req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr ready", int'(req_ready), 1 << (i % 3));
         step();
         chk("rr plot", int'(vga_plot), 1);
         chk("rr x", int'(vga_x), 10 * (i % 3 + 1));
      end
      req_valid = '0;
      step();
      chk("idle plot", int'(vga_plot), 0);
      chk("idle hold x", int'(vga_x), 30);

      // out-of-range then corner pixel
      set_px(1, 160, 10, 5);
      req_valid = 3'b010;
      @(negedge clk);
      chk("oor ready", int'(req_ready), 2);
      step();
      chk("oor x plot", int'(vga_plot), 0);
      chk("oor x drop", int'(drop), 1);
      set_px(1, 10, 120, 4);
      step();
      chk("oor y drop", int'(drop), 1);
      set_px(1, 159, 119, 6);
      step();
      chk("corner plot", int'(vga_plot), 1);
      chk("corner drop", int'(drop), 0);
      chk("corner x", int'(vga_x), 159);
      chk("corner y", int'(vga_y), 119);
      req_valid = '0;
      step();

`ifdef PLOT_ARB_CLEAR_EN
      // leave requester 2 as last grant so requester 0 follows the sweep
      set_px(2, 1, 1, 1);
      req_valid = 3'b100;
      step();
      req_valid = 3'b111;
      clear_start = 1'b1;
      @(negedge clk);
      chk("clear start ready", int'(req_ready), 0);
      step();
      clear_start = 1'b0;
      chk("clear busy", int'(clear_busy), 1);
      chk("clear first cycle plot", int'(vga_plot), 0);
      n = 0; cnt = 0;
      while (!clear_done && n < NPIX + 100) begin
         step();
         n++;
         if (vga_plot) cnt++;
      end
      chk("clear done seen", int'(clear_done), 1);
      chk("clear pixel count", cnt, NPIX);
      chk("clear last x", int'(vga_x), 159);
      chk("clear last y", int'(vga_y), 119);
      chk("clear colour", int'(vga_colour), 0);
      chk("clear busy at done", int'(clear_busy), 1);
      @(negedge clk);
      chk("ready at done", int'(req_ready), 0);
      step();
      chk("busy after", int'(clear_busy), 0);
      chk("done pulse", int'(clear_done), 0);
      @(negedge clk);
      chk("ready after clear", int'(req_ready), 1);
      step();
      req_valid = '0;
      chk("post clear x", int'(vga_x), 10);

      // reset in the middle of a sweep
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      n = 0; cnt = 0;
      while (cnt < 5000 && n < 6000) begin
         step();
         n++;
         if (vga_plot) cnt++;
      end
      chk("mid clear count", cnt, 5000);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("abort plot", int'(vga_plot), 0);
      chk("abort x", int'(vga_x), 0);
      chk("abort y", int'(vga_y), 0);
      chk("abort busy", int'(clear_busy), 0);
      chk("abort done", int'(clear_done), 0);
      req_valid = 3'b111;
      @(negedge clk);
      chk("abort ready", int'(req_ready), 1);
      step();
      req_valid = '0;
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      step();
      chk("restart plot", int'(vga_plot), 1);
      chk("restart x", int'(vga_x), 0);
      chk("restart y", int'(vga_y), 0);
      step();
      chk("restart x2", int'(vga_x), 1);
      do_reset();
`else
      // sweep engine absent: clear_start is ignored
      set_px(0, 5, 5, 5);
      req_valid = 3'b001;
      clear_start = 1'b1;
      @(negedge clk);
      chk("noclr ready", int'(req_ready), 1);
      step();
      clear_start = 1'b0;
      req_valid = '0;
      chk("noclr busy", int'(clear_busy), 0);
      chk("noclr plot", int'(vga_plot), 1);
      chk("noclr x", int'(vga_x), 5);
      step();
      chk("noclr busy2", int'(clear_busy), 0);
      chk("noclr done", int'(clear_done), 0);
`endif
      step(); step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_plot_arbiter
`default_nettype wire
